hs_npu_requant_deskew: RTL and testbench

- Sits directly downstream of the matrix-multiply unit.
- Consumes the diagonally staggered per-column int32 results and their per-column valids.
- Re-aligns them into whole rows and requantizes each element: round, arithmetic shift, optional ReLU, saturation.
- Emits one SIZE-wide row per ready/valid handshake to the writeback/output buffer. Counts rows and signals completion of a programmed tile.

---
 rtl/hs_npu_requant_deskew.sv | 263 ++++++++++++++++++++++++++
 tb/tb_hs_npu_requant_deskew.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_requant_deskew.sv
// hs_npu_requant_deskew: re-aligns the diagonally staggered per-column
// accumulator stream from the systolic array into whole rows, requantizes
// each element (round, arithmetic shift, optional ReLU, saturate) and hands
// one row per ready/valid handshake to the output buffer. A small
// IDLE/RUN/DONE controller counts delivered rows against the programmed
// tile length.
module hs_npu_requant_deskew #(
  parameter int SIZE         = 8,
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int DESKEW_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               start,
  input  logic [15:0]                        rows_total,
  input  logic [4:0]                         shift_amt,
  input  logic                               relu_en,
  input  logic [SIZE-1:0][IN_WIDTH-1:0]      in_data,
  input  logic [SIZE-1:0]                    in_valid,
  output logic [SIZE-1:0][OUT_WIDTH-1:0]     out_row,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               err_overflow
);

  localparam int PTR_W = (DESKEW_DEPTH > 1) ? $clog2(DESKEW_DEPTH) : 1;
  localparam int CNT_W = $clog2(DESKEW_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DESKEW_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DESKEW_DEPTH - 1);

  // Rounding constant and saturation bounds, all at IN_WIDTH+1 bits so the
  // rounding add can never wrap.
  localparam logic signed [IN_WIDTH:0] RND_ONE = (IN_WIDTH+1)'(1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    $signed({{(IN_WIDTH+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    $signed({{(IN_WIDTH+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round-half-up, arithmetic shift, optional ReLU, then clamp to OUT_WIDTH.
  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic [IN_WIDTH-1:0] x,
    input logic [4:0]          sh,
    input logic                relu
  );
    logic signed [IN_WIDTH:0] t_s;
    logic [OUT_WIDTH-1:0]     r_s;
    t_s = $signed({x[IN_WIDTH-1], x});
    if (sh != 5'd0) begin
      t_s = t_s + (RND_ONE << (sh - 5'd1));
    end else begin
      t_s = t_s;
    end
    t_s = t_s >>> sh;
    if (relu && t_s[IN_WIDTH]) begin
      t_s = '0;
    end else begin
      t_s = t_s;
    end
    if (t_s > SAT_MAX) begin
      r_s = SAT_MAX[OUT_WIDTH-1:0];
    end else if (t_s < SAT_MIN) begin
      r_s = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      r_s = t_s[OUT_WIDTH-1:0];
    end
    return r_s;
  endfunction

  state_t                         state_r, state_nxt_s;
  logic [15:0]                    rows_total_r, row_cnt_r;
  logic [4:0]                     shift_r;
  logic                           relu_r;
  logic [IN_WIDTH-1:0]            mem_r    [SIZE][DESKEW_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_r [SIZE];
  logic [PTR_W-1:0]               rd_ptr_r [SIZE];
  logic [CNT_W-1:0]               cnt_r    [SIZE];
  logic [SIZE-1:0]                push_req_s, push_s, ovf_s, full_s, avail_s;
  logic [SIZE-1:0][IN_WIDTH-1:0]  head_s;
  logic [SIZE-1:0][OUT_WIDTH-1:0] rq_row_s;
  logic [SIZE-1:0][OUT_WIDTH-1:0] out_row_r;
  logic                           out_valid_r, busy_r, done_r, err_r;
  logic                           pop_s, hs_s, start_acc_s;

  assign start_acc_s = start && (state_r == ST_IDLE) && !flush;
  assign hs_s        = out_valid_r && out_ready;

  // Per-column head and availability; an empty FIFO being pushed this cycle
  // forwards its input so a row can leave the cycle after its last column.
  always_comb begin
    full_s     = '0;
    avail_s    = '0;
    push_req_s = '0;
    head_s     = '0;
    for (int c = 0; c < SIZE; c++) begin
      push_req_s[c] = in_valid[c] && (state_r == ST_RUN) && !flush;
      full_s[c]     = (cnt_r[c] == DEPTH_C);
      avail_s[c]    = (cnt_r[c] != '0) || push_req_s[c];
      head_s[c]     = (cnt_r[c] != '0) ? mem_r[c][rd_ptr_r[c]] : in_data[c];
    end
  end

  assign pop_s = (&avail_s) && (!out_valid_r || out_ready) && !flush;

  // Push acceptance and overflow detection; a full FIFO being popped still
  // accepts the incoming word.
  always_comb begin
    push_s = '0;
    ovf_s  = '0;
    for (int c = 0; c < SIZE; c++) begin
      push_s[c] = push_req_s[c] && (!full_s[c] || pop_s);
      ovf_s[c]  = push_req_s[c] && full_s[c] && !pop_s;
    end
  end

  // Requantize every column head in parallel.
  always_comb begin
    rq_row_s = '0;
    for (int c = 0; c < SIZE; c++) begin
      rq_row_s[c] = requant(head_s[c], shift_r, relu_r);
    end
  end

  // FIFO pointers and occupancy counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < SIZE; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        cnt_r[c]    <= '0;
      end
    end else if (flush) begin
      for (int c = 0; c < SIZE; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        cnt_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < SIZE; c++) begin
        if (push_s[c]) begin
          wr_ptr_r[c] <= (wr_ptr_r[c] == PTR_LAST) ? '0 : wr_ptr_r[c] + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r[c] <= (rd_ptr_r[c] == PTR_LAST) ? '0 : rd_ptr_r[c] + PTR_W'(1);
        end
        case ({push_s[c], pop_s})
          2'b10:   cnt_r[c] <= cnt_r[c] + CNT_W'(1);
          2'b01:   cnt_r[c] <= cnt_r[c] - CNT_W'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    for (int c = 0; c < SIZE; c++) begin
      if (push_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= in_data[c];
      end
    end
  end

  // Output row register: load on pop, drop valid on a bare handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_row_r   <= '0;
      out_valid_r <= 1'b0;
    end else if (pop_s) begin
      out_row_r   <= rq_row_s;
      out_valid_r <= 1'b1;
    end else if (hs_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Tile controller next state.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_nxt_s = (rows_total == 16'd0) ? ST_DONE : ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (hs_s && ((row_cnt_r + 16'd1) == rows_total_r)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Tile configuration latch and delivered-row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_total_r <= 16'd0;
      shift_r      <= 5'd0;
      relu_r       <= 1'b0;
      row_cnt_r    <= 16'd0;
    end else if (start_acc_s) begin
      rows_total_r <= rows_total;
      shift_r      <= shift_amt;
      relu_r       <= relu_en;
      row_cnt_r    <= 16'd0;
    end else if (hs_s) begin
      row_cnt_r    <= row_cnt_r + 16'd1;
    end
  end

  // Sticky overflow flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (|ovf_s) begin
      err_r <= 1'b1;
    end
  end

  assign out_row      = out_row_r;
  assign out_valid    = out_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err_overflow = err_r;

endmodule

// File: tb/tb_hs_npu_requant_deskew.sv
// Self-checking bench for hs_npu_requant_deskew: directed scenarios plus
// randomized tiles scored against a per-column sequence model where row k is
// simply the requantized k-th accepted value of every column.
module tb_hs_npu_requant_deskew;

  localparam int SIZE = 8;
  localparam int IN_WIDTH = 32;
  localparam int OUT_WIDTH = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic start = 1'b0;
  logic [15:0] rows_total = 16'd0;
  logic [4:0] shift_amt = 5'd0;
  logic relu_en = 1'b0;
  logic [SIZE-1:0][IN_WIDTH-1:0] in_data = '0;
  logic [SIZE-1:0] in_valid = '0;
  logic [SIZE-1:0][OUT_WIDTH-1:0] out_row;
  logic out_valid;
  logic out_ready = 1'b0;
  logic busy, done, err_overflow;

  hs_npu_requant_deskew #(
    .SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .DESKEW_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
    .rows_total(rows_total), .shift_amt(shift_amt), .relu_en(relu_en),
    .in_data(in_data), .in_valid(in_valid), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int mvals[SIZE][256];
  int mcnt[SIZE];
  int hs_cnt = 0;
  int done_cnt = 0;
  int last_hs_cyc = -10;
  bit model_on = 1'b0;
  int m_rows = 0;
  int m_shift = 0;
  bit m_relu = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: observed %0d, required %0d", tag, got, exp);
  endtask

  function automatic longint rq(input int x, input int sh, input bit relu);
    longint t;
    t = longint'(x);
    if (sh > 0) t = t + (longint'(1) << (sh - 1));
    t = t >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  function automatic int rdata();
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom);
      1: v = int'($urandom_range(0, 2000)) - 1000;
      2: v = ($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h80000000;
      default: v = int'($urandom) >>> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // One cycle: record pushes, score the visible row, then advance.
  task automatic step();
    int min_cnt;
    if (model_on) begin
      for (int c = 0; c < SIZE; c++) begin
        if (in_valid[c] && mcnt[c] < 256) begin
          mvals[c][mcnt[c]] = int'(in_data[c]);
          mcnt[c]++;
        end
      end
      if (out_valid) begin
        min_cnt = mcnt[0];
        for (int c = 1; c < SIZE; c++) if (mcnt[c] < min_cnt) min_cnt = mcnt[c];
        check("row_available", longint'(min_cnt > hs_cnt), 1);
        if (min_cnt > hs_cnt) begin
          for (int c = 0; c < SIZE; c++)
            check($sformatf("row%0d_col%0d", hs_cnt, c), longint'($signed(out_row[c])),
                  rq(mvals[c][hs_cnt], m_shift, m_relu));
        end
      end
      if (done && m_rows != 0) check("done_after_last_hs", cyc, last_hs_cyc + 1);
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_tile(input int rows, input int sh, input bit relu);
    m_rows = rows; m_shift = sh; m_relu = relu;
    for (int c = 0; c < SIZE; c++) mcnt[c] = 0;
    hs_cnt = 0; done_cnt = 0; last_hs_cyc = -10;
    in_valid = '0;
    rows_total = 16'(rows); shift_amt = 5'(sh); relu_en = relu;
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic finish_tile();
    int n;
    in_valid = '0;
    n = 0;
    while (done_cnt == 0 && n < 300) begin
      out_ready = ($urandom_range(0, 99) < 70);
      step();
      n++;
    end
    check("tile_done_seen", done_cnt, 1);
    check("tile_rows_delivered", hs_cnt, m_rows);
    check("done_single_pulse", done, 0);
    check("busy_low_after_tile", busy, 0);
    check("no_valid_after_tile", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pc[SIZE];
    int guard;
    bit all_in;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_overflow, 0);
    for (int c = 0; c < SIZE; c++) check($sformatf("rst_row_col%0d", c), out_row[c], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Staggered single row, exact latency.
    model_on = 1'b1;
    out_ready = 1'b1;
    begin_tile(1, 0, 0);
    while (cyc <= 20) begin
      in_valid = '0;
      for (int c = 0; c < SIZE; c++) begin
        if (cyc == 10 + c) begin
          in_valid[c] = 1'b1;
          in_data[c] = 32'(100 * (c + 1));
        end
      end
      check($sformatf("t1_valid_c%0d", cyc), out_valid, longint'(cyc == 18));
      check($sformatf("t1_done_c%0d", cyc), done, longint'(cyc == 19));
      check($sformatf("t1_busy_c%0d", cyc), busy, longint'(cyc >= 1 && cyc <= 18));
      if (cyc == 18)
        for (int c = 0; c < SIZE; c++) check($sformatf("t1_col%0d", c), out_row[c], 100 * (c + 1));
      step();
    end
    in_valid = '0;
    check("t1_done_count", done_cnt, 1);

    // Rounding and saturation.
    begin_tile(1, 4, 0);
    in_valid = '1;
    in_data[0] = 32'(40); in_data[1] = 32'(-40); in_data[2] = 32'(24);
    in_data[3] = 32'h7FFFFFFF; in_data[4] = 32'h80000000;
    in_data[5] = 32'(0); in_data[6] = 32'(-1); in_data[7] = 32'(12345678);
    out_ready = 1'b0;
    step();
    in_valid = '0;
    check("t2_valid", out_valid, 1);
    check("t2_round_pos", longint'($signed(out_row[0])), 3);
    check("t2_round_neg", longint'($signed(out_row[1])), -2);
    check("t2_round_half", longint'($signed(out_row[2])), 2);
    check("t2_sat_max", longint'($signed(out_row[3])), 32767);
    check("t2_sat_min", longint'($signed(out_row[4])), -32768);
    finish_tile();

    // ReLU.
    begin_tile(1, 1, 1);
    in_valid = '1;
    for (int c = 0; c < SIZE; c++) in_data[c] = 32'(rdata());
    in_data[0] = 32'(-5); in_data[1] = 32'(5);
    out_ready = 1'b0;
    step();
    in_valid = '0;
    check("t3_relu_neg", longint'($signed(out_row[0])), 0);
    check("t3_relu_pos", longint'($signed(out_row[1])), 3);
    finish_tile();

    // Backpressure: four back-to-back rows, ready low for five cycles.
    begin_tile(4, 2, 0);
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      in_valid = '1;
      for (int c = 0; c < SIZE; c++) in_data[c] = 32'(rdata());
      step();
    end
    in_valid = '0;
    step();
    check("t4_valid_held", out_valid, 1);
    check("t4_no_hs_yet", hs_cnt, 0);
    finish_tile();

    // Overflow on column 0 while column 7 is silent.
    model_on = 1'b0;
    begin_tile(1, 0, 0);
    for (int k = 0; k < 16; k++) begin
      in_valid = '0;
      in_valid[0] = 1'b1;
      in_data[0] = 32'(k);
      step();
    end
    in_valid = '0;
    check("t5_ovf_not_at_depth", err_overflow, 0);
    in_valid[0] = 1'b1;
    step();
    in_valid = '0;
    check("t5_ovf_set", err_overflow, 1);
    check("t5_still_busy", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_ovf_kept_by_flush", err_overflow, 1);
    check("t5_flush_idle", busy, 0);

    // Zero-row tile, also clears the overflow flag.
    model_on = 1'b1;
    begin_tile(0, 0, 0);
    check("t6_done", done, 1);
    check("t6_busy", busy, 0);
    check("t6_no_valid", out_valid, 0);
    check("t6_ovf_cleared", err_overflow, 0);
    step();
    check("t6_done_one_cycle", done, 0);

    // Flush with three partial rows.
    model_on = 1'b0;
    begin_tile(5, 0, 0);
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      in_valid = 8'h7F;
      for (int c = 0; c < SIZE; c++) in_data[c] = 32'(rdata());
      step();
    end
    in_valid = '0;
    check("t7_partial_no_valid", out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t7_flush_valid", out_valid, 0);
    check("t7_flush_busy", busy, 0);
    check("t7_flush_done", done, 0);
    for (int c = 0; c < SIZE; c++) check($sformatf("t7_flush_row_col%0d", c), out_row[c], 0);
    step();
    check("t7_no_done_pulse", done, 0);
    model_on = 1'b1;
    begin_tile(1, 0, 0);
    in_valid = '1;
    for (int c = 0; c < SIZE; c++) in_data[c] = 32'(1000 + c);
    step();
    in_valid = '0;
    finish_tile();

    // Asynchronous reset in the middle of a tile.
    model_on = 1'b0;
    begin_tile(3, 0, 0);
    out_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      in_valid = '1;
      for (int c = 0; c < SIZE; c++) in_data[c] = 32'(rdata());
      step();
    end
    in_valid = '0;
    step();
    check("t8_pre_valid", out_valid, 1);
    check("t8_pre_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check("t8_rst_valid", out_valid, 0);
    check("t8_rst_busy", busy, 0);
    check("t8_rst_done", done, 0);
    check("t8_rst_err", err_overflow, 0);
    for (int c = 0; c < SIZE; c++) check($sformatf("t8_rst_row_col%0d", c), out_row[c], 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Randomized tiles with random skew and backpressure.
    model_on = 1'b1;
    for (int t = 0; t < 6; t++) begin
      begin_tile(int'($urandom_range(1, 20)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < SIZE; c++) pc[c] = 0;
      guard = 0;
      all_in = 1'b0;
      while (!all_in && guard < 2000) begin
        for (int c = 0; c < SIZE; c++) begin
          in_valid[c] = (pc[c] < m_rows) && (pc[c] - hs_cnt < DEPTH - 2) &&
                        ($urandom_range(0, 99) < 60);
          if (in_valid[c]) begin
            in_data[c] = 32'(rdata());
            pc[c]++;
          end
        end
        out_ready = ($urandom_range(0, 99) < 70);
        step();
        guard++;
        all_in = 1'b1;
        for (int c = 0; c < SIZE; c++) if (pc[c] < m_rows) all_in = 1'b0;
      end
      in_valid = '0;
      check($sformatf("rand%0d_no_overflow", t), err_overflow, 0);
      finish_tile();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
